// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display with double-buffered input.
// Define SEVSEG_LZB_EN to build in leading-zero blanking; the default build shows zeros unconditionally.
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      4'hF:    glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, disp_blank_q, disp_blank_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    tick_s, wrap_s;
  logic [NUM_DIGITS-1:0]   sel_s, eff_blank_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_blank_s, cur_dp_s;
`ifdef SEVSEG_LZB_EN
  logic                    higher_zero_s;
`endif

  // Effective per-digit blanking, derived from the display register so it holds for a whole frame
  always_comb begin
    eff_blank_s = disp_blank_q;
`ifdef SEVSEG_LZB_EN
    higher_zero_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (higher_zero_s && (disp_val_q[4*i +: 4] == 4'h0) && !disp_dp_q[i]) begin
        eff_blank_s[i] = 1'b1;
      end else begin
        eff_blank_s[i] = disp_blank_q[i];
      end
      higher_zero_s = higher_zero_s && (disp_blank_q[i] || (disp_val_q[4*i +: 4] == 4'h0));
    end
`endif
  end

  // Scan timing, double buffering and next output values
  always_comb begin
    tick_s = (cnt_q == CNT_LAST);
    wrap_s = tick_s && (idx_q == IDX_LAST);
    cnt_d  = tick_s ? '0 : cnt_q + CW'(1'b1);
    if (wrap_s) begin
      idx_d = '0;
    end else if (tick_s) begin
      idx_d = idx_q + IW'(1'b1);
    end else begin
      idx_d = idx_q;
    end

    if (load) begin
      stg_val_d   = value_in;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
    end else begin
      stg_val_d   = stg_val_q;
      stg_dp_d    = stg_dp_q;
      stg_blank_d = stg_blank_q;
    end
    // A load coinciding with the wrap goes straight through to the display
    if (wrap_s) begin
      disp_val_d   = stg_val_d;
      disp_dp_d    = stg_dp_d;
      disp_blank_d = stg_blank_d;
    end else begin
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      disp_blank_d = disp_blank_q;
    end

    cur_nib_s = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_s[i]  = (idx_q == IW'(i));
      cur_nib_s = cur_nib_s | (disp_val_q[4*i +: 4] & {4{sel_s[i]}});
    end
    cur_blank_s = |(sel_s & eff_blank_s);
    cur_dp_s    = |(sel_s & disp_dp_q);

    if (tick_s || cur_blank_s) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~sel_s;
      seg_d = glyph(cur_nib_s);
      dp_d  = ~cur_dp_s;
    end
    fd_d = wrap_s;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      stg_val_q    <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '1;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      fd_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stg_val_q    <= stg_val_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fd_q         <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan (4 digits, 4 clocks per slot): slot-arithmetic scoreboard plus directed literal checks.
// Leading-zero blanking expectations are enabled when SEVSEG_LZB_EN is defined.
module tb_seven_seg_scan;

  localparam int NUM_DIGITS = 4;
  localparam int CLK_DIV    = 4;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic        load = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seven_seg_scan #(.NUM_DIGITS(NUM_DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edges since reset plus the staging/display contents
  bit          m_valid = 1'b0;
  int          m_kk = 0;
  logic [15:0] m_stg_val, m_disp_val;
  logic [3:0]  m_stg_dp, m_disp_dp, m_stg_blank, m_disp_blank;

  function automatic bit model_blank(input int d);
    if (m_disp_blank[d]) return 1'b1;
`ifdef SEVSEG_LZB_EN
    if (d > 0 && m_disp_val[4*d +: 4] == 4'h0 && !m_disp_dp[d]) begin
      for (int j = d + 1; j < NUM_DIGITS; j++)
        if (!(m_disp_blank[j] || m_disp_val[4*j +: 4] == 4'h0)) return 1'b0;
      return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid      <= 1'b1;
      m_kk         <= 0;
      m_stg_val    <= 16'h0000;
      m_stg_dp     <= 4'h0;
      m_stg_blank  <= 4'hF;
      m_disp_val   <= 16'h0000;
      m_disp_dp    <= 4'h0;
      m_disp_blank <= 4'hF;
    end else begin
      m_kk <= m_kk + 1;
      if (load) begin
        m_stg_val   <= value_in;
        m_stg_dp    <= dp_in;
        m_stg_blank <= blank_in;
      end
      if ((m_kk % CLK_DIV == CLK_DIV - 1) && ((m_kk / CLK_DIV) % NUM_DIGITS == NUM_DIGITS - 1)) begin
        m_disp_val   <= load ? value_in : m_stg_val;
        m_disp_dp    <= load ? dp_in    : m_stg_dp;
        m_disp_blank <= load ? blank_in : m_stg_blank;
      end
    end
  end

  always @(negedge clk) begin : scoreboard
    int e, ph, dg;
    logic [3:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp, x_fd;
    if (m_valid) begin
      x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1; x_fd = 1'b0;
      if (!rst && m_kk > 0) begin
        e  = m_kk - 1;
        ph = e % CLK_DIV;
        dg = (e / CLK_DIV) % NUM_DIGITS;
        if (ph == CLK_DIV - 1) begin
          x_fd = (dg == NUM_DIGITS - 1);
        end else if (!model_blank(dg)) begin
          x_an  = ~(4'b0001 << dg);
          x_seg = GLYPH[m_disp_val[4*dg +: 4]];
          x_dp  = ~m_disp_dp[dg];
        end
      end
      if (!rst) begin
        check("sb_an_out", an_out, x_an);
        check("sb_seg_out", seg_out, x_seg);
        check("sb_dp_out", dp_out, x_dp);
        check("sb_frame_done", frame_done, x_fd);
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value_in = v; dp_in = d; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic expect_slot(input string nm, input logic [3:0] a, input logic [6:0] s, input logic d);
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (an_out == a) begin ok = 1'b1; break; end
    end
    check({nm, "_reached"}, ok, 1);
    if (ok) begin
      check({nm, "_seg"}, seg_out, s);
      check({nm, "_dp"}, dp_out, d);
    end
  endtask

  task automatic wait_fd(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
    check({nm, "_frame_done"}, ok, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt_a, cnt_b;
    bit ok;
    repeat (2) @(negedge clk);
    check("reset_an", an_out, 4'hF);
    check("reset_seg", seg_out, 7'h7F);
    check("reset_dp", dp_out, 1'b1);
    check("reset_fd", frame_done, 1'b0);
    rst = 1'b0;

    // Idle: dark display, frame_done every 16 cycles
    cnt_a = 0; cnt_b = 0;
    repeat (64) begin
      @(negedge clk);
      if (frame_done) cnt_a++;
      if (an_out != 4'hF) cnt_b++;
    end
    check("idle_fd_pulses", cnt_a, 4);
    check("idle_lit_cycles", cnt_b, 0);

    do_load(16'h12AF, 4'b0100, 4'b0000);
    wait_fd("load1");
    expect_slot("d0_F", 4'hE, 7'h0E, 1'b1);
    expect_slot("d1_A", 4'hD, 7'h08, 1'b1);
    expect_slot("d2_2", 4'hB, 7'h24, 1'b0);
    expect_slot("d3_1", 4'h7, 7'h79, 1'b1);

    // Load mid-frame while digit 1 is lit
    expect_slot("mid_d1", 4'hD, 7'h08, 1'b1);
    do_load(16'h3333, 4'b0000, 4'b0000);
    expect_slot("mid_d2_old", 4'hB, 7'h24, 1'b0);
    expect_slot("mid_d3_old", 4'h7, 7'h79, 1'b1);
    wait_fd("mid");
    expect_slot("mid_d0_new", 4'hE, 7'h30, 1'b1);

    // Load exactly on the wrap edge
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((m_kk % CLK_DIV == CLK_DIV - 1) && ((m_kk / CLK_DIV) % NUM_DIGITS == NUM_DIGITS - 1)) begin
        ok = 1'b1; break;
      end
      @(negedge clk);
    end
    check("wrap_edge_found", ok, 1);
    do_load(16'h0009, 4'b0000, 4'b0000);
    check("wrap_fd", frame_done, 1'b1);
    check("wrap_dead_an", an_out, 4'hF);
    expect_slot("wrap_d0", 4'hE, 7'h10, 1'b1);
    expect_slot("wrap_d1", 4'hD, 7'h40, 1'b1);

    // Blanked digit with dp requested
    do_load(16'h4321, 4'b0010, 4'b0010);
    wait_fd("blank");
    cnt_a = 0; cnt_b = 0;
    repeat (32) begin
      @(negedge clk);
      if (!an_out[1]) cnt_a++;
      if (!dp_out) cnt_b++;
    end
    check("blank_an1_low", cnt_a, 0);
    check("blank_dp_low", cnt_b, 0);
    expect_slot("blank_d0", 4'hE, 7'h79, 1'b1);
    expect_slot("blank_d2", 4'hB, 7'h30, 1'b1);

    // Reset mid-slot
    expect_slot("pre_rst_d0", 4'hE, 7'h79, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", an_out, 4'hF);
    check("midrst_seg", seg_out, 7'h7F);
    check("midrst_dp", dp_out, 1'b1);
    check("midrst_fd", frame_done, 1'b0);
    rst = 1'b0;
    cnt_a = 0;
    repeat (40) begin
      @(negedge clk);
      if (an_out != 4'hF) cnt_a++;
    end
    check("post_rst_dark", cnt_a, 0);

`ifdef SEVSEG_LZB_EN
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_fd("lzb1");
    expect_slot("lzb_d1", 4'hD, 7'h12, 1'b1);
    expect_slot("lzb_d0", 4'hE, 7'h40, 1'b1);
    cnt_a = 0;
    repeat (16) begin
      @(negedge clk);
      if (!an_out[3] || !an_out[2]) cnt_a++;
    end
    check("lzb_upper_dark", cnt_a, 0);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_fd("lzb2");
    cnt_a = 0;
    repeat (16) begin
      @(negedge clk);
      if (an_out != 4'hF && an_out != 4'hE) cnt_a++;
    end
    check("lzb_only_d0", cnt_a, 0);
    expect_slot("lzb_zero_d0", 4'hE, 7'h40, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
